// File: rtl/dna_port_param_if.sv
// Serial DNA port signals plus the parallel readout result.
// master drives the requests; slave is the DNA port model.
interface dna_port_param_if #(
    parameter int DNA_WIDTH = 96
);
    logic                 DIN;
    logic                 READ;
    logic                 SHIFT;
    logic                 START;
    logic                 DOUT;
    logic                 BUSY;
    logic                 VALID;
    logic [DNA_WIDTH-1:0] DNA_OUT;

    modport master (
        output DIN, READ, SHIFT, START,
        input  DOUT, BUSY, VALID, DNA_OUT
    );

    modport slave (
        input  DIN, READ, SHIFT, START,
        output DOUT, BUSY, VALID, DNA_OUT
    );
endinterface

// File: rtl/dna_port_param.sv
// Parametrised device-DNA port model.
// Adds an autonomous readout engine that publishes the ID as a parallel word.
module dna_port_param #(
    parameter int                   DNA_WIDTH     = 96,
    parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = '0,
    parameter bit                   LSB_FIRST     = 1'b0
) (
    input  logic           CLK,
    input  logic           RST,
    dna_port_param_if.slave io
);
    localparam int CW = $clog2(DNA_WIDTH + 1);
    localparam logic [DNA_WIDTH-1:0] MAX_VAL =
        {DNA_WIDTH{1'b1}} - DNA_WIDTH'(2);

    if (DNA_WIDTH < 2 || DNA_WIDTH > 128 || SIM_DNA_VALUE > MAX_VAL) begin : g_bad_param
        $fatal(1, "%m: illegal DNA_WIDTH or SIM_DNA_VALUE");
    end

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t               state, state_n;
    logic [DNA_WIDTH-1:0] sreg, sreg_n;
    logic [DNA_WIDTH-1:0] cap, cap_n;
    logic [DNA_WIDTH-1:0] dna_q, dna_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 dout_q, dout_n;
    logic                 busy_q, busy_n;
    logic                 valid_q, valid_n;
    logic                 ob;

    function automatic logic ob_of(input logic [DNA_WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[DNA_WIDTH-1];
    endfunction

    // Entering bit lands at the end opposite the outgoing one.
    function automatic logic [DNA_WIDTH-1:0] shift_in(
        input logic [DNA_WIDTH-1:0] v,
        input logic                 b
    );
        if (LSB_FIRST)
            return (v >> 1) | (DNA_WIDTH'(b) << (DNA_WIDTH - 1));
        else
            return (v << 1) | DNA_WIDTH'(b);
    endfunction

    assign ob = ob_of(sreg);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            sreg    <= SIM_DNA_VALUE;
            cap     <= '0;
            cnt     <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dna_q   <= '0;
        end else begin
            state   <= state_n;
            sreg    <= sreg_n;
            cap     <= cap_n;
            cnt     <= cnt_n;
            dout_q  <= dout_n;
            busy_q  <= busy_n;
            valid_q <= valid_n;
            dna_q   <= dna_n;
        end
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cap_n   = cap;
        cnt_n   = cnt;
        dout_n  = dout_q;
        busy_n  = busy_q;
        valid_n = valid_q;
        dna_n   = dna_q;
        unique case (state)
            S_IDLE: begin
                if (io.START) begin
                    sreg_n  = SIM_DNA_VALUE;
                    cnt_n   = '0;
                    valid_n = 1'b0;
                    busy_n  = 1'b1;
                    dout_n  = ob_of(SIM_DNA_VALUE);
                    state_n = S_RUN;
                end else if (io.READ) begin
                    sreg_n = SIM_DNA_VALUE;
                    dout_n = ob_of(SIM_DNA_VALUE);
                end else if (io.SHIFT) begin
                    sreg_n = shift_in(sreg, io.DIN);
                    dout_n = ob_of(sreg_n);
                end
            end
            S_RUN: begin
                // Rotating restores sreg; capture rebuilds the original order.
                cap_n  = shift_in(cap, ob);
                sreg_n = shift_in(sreg, ob);
                dout_n = ob_of(sreg_n);
                cnt_n  = cnt + CW'(1);
                if (cnt == CW'(DNA_WIDTH - 1)) begin
                    dna_n   = cap_n;
                    valid_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign io.DOUT    = dout_q;
    assign io.BUSY    = busy_q;
    assign io.VALID   = valid_q;
    assign io.DNA_OUT = dna_q;
endmodule

// File: tb/tb_dna_port_param.sv
// Scoreboard bench for dna_port_param: MSB-first 96-bit and LSB-first 8-bit.
// Expected bits/words are queued at stimulus time and popped at output time.
module tb_dna_port_param;
    localparam int          WA = 96;
    localparam logic [95:0] VA = 96'hA512_3456_789A_BCDE_F012_343C;
    localparam int          WB = 8;
    localparam logic [7:0]  VB = 8'hB4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic         dout_q[$];
    logic [127:0] dna_q[$];
    logic [95:0]  msa;
    logic [7:0]   msb;

    dna_port_param_if #(.DNA_WIDTH(WA)) ia();
    dna_port_param_if #(.DNA_WIDTH(WB)) ib();

    dna_port_param #(
        .DNA_WIDTH(WA), .SIM_DNA_VALUE(VA), .LSB_FIRST(1'b0)
    ) u_a (.CLK(clk), .RST(rst), .io(ia));

    dna_port_param #(
        .DNA_WIDTH(WB), .SIM_DNA_VALUE(VB), .LSB_FIRST(1'b1)
    ) u_b (.CLK(clk), .RST(rst), .io(ib));

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_man(input logic rd, input logic sh, input logic di);
        ia.READ = rd; ia.SHIFT = sh; ia.DIN = di;
        if (rd) msa = VA;
        else if (sh) msa = {msa[94:0], di};
        if (rd | sh) dout_q.push_back(msa[95]);
        tick;
        if (rd | sh) chk("a_dout", ia.DOUT, dout_q.pop_front());
        ia.READ = 0; ia.SHIFT = 0; ia.DIN = 0;
    endtask

    task automatic b_man(input logic rd, input logic sh, input logic di);
        ib.READ = rd; ib.SHIFT = sh; ib.DIN = di;
        if (rd) msb = VB;
        else if (sh) msb = {di, msb[7:1]};
        if (rd | sh) dout_q.push_back(msb[0]);
        tick;
        if (rd | sh) chk("b_dout", ib.DOUT, dout_q.pop_front());
        ib.READ = 0; ib.SHIFT = 0; ib.DIN = 0;
    endtask

    task automatic a_auto(input bit noise, input bit extra);
        int busy_n;
        bit done;
        ia.START = 1; ia.READ = extra; ia.SHIFT = extra; ia.DIN = extra;
        dna_q.push_back(128'(VA));
        msa = VA;
        tick;
        ia.START = 0; ia.READ = 0; ia.SHIFT = 0; ia.DIN = 0;
        chk("a_busy_on", ia.BUSY, 1);
        chk("a_valid_clr", ia.VALID, 0);
        busy_n = 1;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (noise) begin
                ia.START = 1; ia.READ = 1; ia.SHIFT = 1; ia.DIN = i[0];
            end
            tick;
            if (ia.VALID) done = 1;
            else if (ia.BUSY) busy_n++;
        end
        ia.START = 0; ia.READ = 0; ia.SHIFT = 0; ia.DIN = 0;
        chk("a_done", done, 1);
        chk("a_busy_len", busy_n, WA);
        chk("a_busy_off", ia.BUSY, 0);
        chk("a_dna", ia.DNA_OUT, dna_q.pop_front());
        chk("a_dout_end", ia.DOUT, msa[95]);
    endtask

    task automatic b_auto;
        int busy_n;
        bit done;
        ib.START = 1;
        dna_q.push_back(128'(VB));
        msb = VB;
        tick;
        ib.START = 0;
        chk("b_busy_on", ib.BUSY, 1);
        busy_n = 1;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            tick;
            if (ib.VALID) done = 1;
            else if (ib.BUSY) busy_n++;
        end
        chk("b_done", done, 1);
        chk("b_busy_len", busy_n, WB);
        chk("b_dna", ib.DNA_OUT, dna_q.pop_front());
        chk("b_dout_end", ib.DOUT, msb[0]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int vcnt;
        ia.DIN = 0; ia.READ = 0; ia.SHIFT = 0; ia.START = 0;
        ib.DIN = 0; ib.READ = 0; ib.SHIFT = 0; ib.START = 0;
        msa = VA;
        msb = VB;
        repeat (3) tick;
        chk("rst_dout", ia.DOUT, 0);
        chk("rst_busy", ia.BUSY, 0);
        chk("rst_valid", ia.VALID, 0);
        chk("rst_dna", ia.DNA_OUT, 0);
        chk("rst_b_valid", ib.VALID, 0);
        rst = 0;
        tick;

        // Manual READ then 96 shifts of ones, then a few zeros.
        a_man(1, 0, 0);
        for (int j = 0; j < WA; j++) a_man(0, 1, 1);
        chk("a_all_ones", msa, {WA{1'b1}});
        for (int j = 0; j < 3; j++) a_man(0, 1, 0);

        // Two automatic readouts back to back.
        a_auto(0, 0);
        chk("a_valid_hold", ia.VALID, 1);
        a_auto(0, 0);

        // Requests ignored while running.
        a_auto(1, 0);

        // START beats READ and SHIFT.
        a_auto(0, 1);

        // READ beats SHIFT.
        for (int j = 0; j < 3; j++) a_man(0, 1, 0);
        a_man(1, 1, 1);
        a_man(0, 1, 0);
        a_man(0, 0, 1);
        chk("a_idle_hold", ia.DOUT, msa[95]);

        // Asynchronous reset mid-readout.
        ia.START = 1;
        tick;
        ia.START = 0;
        repeat (40) tick;
        chk("a_busy_mid", ia.BUSY, 1);
        #2 rst = 1;
        #1;
        chk("arst_busy", ia.BUSY, 0);
        chk("arst_valid", ia.VALID, 0);
        chk("arst_dna", ia.DNA_OUT, 0);
        chk("arst_dout", ia.DOUT, 0);
        @(negedge clk);
        rst = 0;
        msa = VA;
        vcnt = 0;
        for (int j = 0; j < 120; j++) begin
            tick;
            if (ia.VALID || ia.BUSY) vcnt++;
        end
        chk("a_no_partial", vcnt, 0);
        chk("a_dna_zero", ia.DNA_OUT, 0);

        // LSB-first 8-bit instance.
        b_man(1, 0, 0);
        for (int j = 0; j < WB - 1; j++) b_man(0, 1, 0);
        b_auto();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
